cfg_out_pea_loader: RTL and testbench

- Write-side counterpart of the per-row PEA output-selector configuration store.
- Accepts configuration words over a valid/ready stream and writes them into the selector array, one configuration slot (KMEM address) per beat, starting from a programmable base slot.
- Drives the full selector array that the configuration-address-indexed output mux reads.
- Sits between the configuration DMA/bus front-end and the PEA output crossbar selectors.

---
 rtl/cfg_out_pea_loader.sv | 98 +++++++++
 tb/tb_cfg_out_pea_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_out_pea_loader.sv
// Stream loader for the per-row PEA output-selector configuration store.
// Each accepted word fills one KMEM slot of every [row][output] selector, starting at a base slot.
module cfg_out_pea_loader #(
    parameter int N               = 4,
    parameter int KMEM_SIZE       = 8,
    parameter int LOG_M           = 3,
    parameter int N_CFG_ADDR_BITS = 3
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          start_i,
    input  logic [N_CFG_ADDR_BITS-1:0]                    base_slot_i,
    input  logic [N_CFG_ADDR_BITS:0]                      n_slots_i,
    input  logic                                          abort_i,
    input  logic                                          cfg_valid_i,
    input  logic [2*N*LOG_M-1:0]                          cfg_data_i,
    output logic                                          cfg_ready_o,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic [N-1:0][1:0][KMEM_SIZE-1:0][LOG_M-1:0]   reg_cfg_sel_out_pea_o
);

    localparam logic [N_CFG_ADDR_BITS:0]   MAX_COUNT = (N_CFG_ADDR_BITS+1)'(KMEM_SIZE);
    localparam logic [N_CFG_ADDR_BITS-1:0] LAST_SLOT = N_CFG_ADDR_BITS'(KMEM_SIZE-1);
    localparam logic [N_CFG_ADDR_BITS:0]   ONE_LEFT  = (N_CFG_ADDR_BITS+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state, state_next;
    logic [N_CFG_ADDR_BITS-1:0] ptr;
    logic [N_CFG_ADDR_BITS:0]   rem;
    logic                       accept;
    logic                       launch;

    function automatic logic [N_CFG_ADDR_BITS:0] sat_count(input logic [N_CFG_ADDR_BITS:0] n);
        if (n > MAX_COUNT) return MAX_COUNT;
        return n;
    endfunction

    function automatic logic [N_CFG_ADDR_BITS-1:0] next_slot(input logic [N_CFG_ADDR_BITS-1:0] p);
        if (p == LAST_SLOT) return '0;
        return p + 1'b1;
    endfunction

    // Abort wins over a same-cycle beat, so that beat is never written.
    assign accept = (state == LOAD) && cfg_valid_i && !abort_i;
    assign launch = (state == IDLE) && start_i && (n_slots_i != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) state_next = (n_slots_i == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (abort_i)                            state_next = IDLE;
                else if (cfg_valid_i && rem == ONE_LEFT) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_o = (state == LOAD);
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr                   <= '0;
            rem                   <= '0;
            reg_cfg_sel_out_pea_o <= '0;
        end else if (launch) begin
            ptr <= base_slot_i;
            rem <= sat_count(n_slots_i);
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < 2; j++) begin
                    reg_cfg_sel_out_pea_o[i][j][ptr] <= cfg_data_i[(i*2+j)*LOG_M +: LOG_M];
                end
            end
            ptr <= next_slot(ptr);
            rem <= rem - 1'b1;
        end
    end

endmodule

// File: tb/tb_cfg_out_pea_loader.sv
// Bench for cfg_out_pea_loader: table of straight loads plus hand-written
// backpressure, abort and reset sequences, with a write scoreboard.
module tb_cfg_out_pea_loader;

    localparam int N     = 4;
    localparam int KMEM  = 8;
    localparam int LOG_M = 3;
    localparam int AW    = 3;
    localparam int WW    = 2*N*LOG_M;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   n;
        int            beats;
        logic [WW-1:0] word0;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] slot;
        logic [WW-1:0] word;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW-1:0] base_slot = '0;
    logic [AW:0]   n_slots = '0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_ready, busy, done;
    logic [N-1:0][1:0][KMEM-1:0][LOG_M-1:0] sel_arr;
    logic [N-1:0][1:0][KMEM-1:0][LOG_M-1:0] exp_arr;

    int  checks = 0;
    int  failures = 0;
    sb_t sbq[$];
    vec_t vecs[5];

    cfg_out_pea_loader #(
        .N(N), .KMEM_SIZE(KMEM), .LOG_M(LOG_M), .N_CFG_ADDR_BITS(AW)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .start_i               (start),
        .base_slot_i           (base_slot),
        .n_slots_i             (n_slots),
        .abort_i               (abort),
        .cfg_valid_i           (cfg_valid),
        .cfg_data_i            (cfg_data),
        .cfg_ready_o           (cfg_ready),
        .busy_o                (busy),
        .done_o                (done),
        .reg_cfg_sel_out_pea_o (sel_arr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_array(input string name);
        checks++;
        if (sel_arr !== exp_arr) begin
            failures++;
            $display("FAIL %s: array got %h expected %h", name, sel_arr, exp_arr);
        end
    endtask

    task automatic check_ctl(input string name, input logic r, input logic b, input logic d);
        check({name, ".ready"}, 64'(cfg_ready), 64'(r));
        check({name, ".busy"},  64'(busy),      64'(b));
        check({name, ".done"},  64'(done),      64'(d));
    endtask

    function automatic logic [WW-1:0] slot_word(input logic [AW-1:0] s);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2; j++)
                w[(i*2+j)*LOG_M +: LOG_M] = sel_arr[i][j][s];
        return w;
    endfunction

    task automatic push_beat(input logic [AW-1:0] slot, input logic [WW-1:0] word);
        sb_t e;
        e.slot = slot;
        e.word = word;
        sbq.push_back(e);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2; j++)
                exp_arr[i][j][slot] = word[(i*2+j)*LOG_M +: LOG_M];
    endtask

    task automatic pop_check(input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, no expected write", name);
        end else begin
            e = sbq.pop_front();
            check(name, 64'(slot_word(e.slot)), 64'(e.word));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        logic [AW-1:0] s;
        base_slot = v.base;
        n_slots   = v.n;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        for (int k = 0; k < v.beats; k++) begin
            check_ctl("load", 1'b1, 1'b1, 1'b0);
            cfg_valid = 1'b1;
            cfg_data  = (k == 0) ? v.word0 : WW'($urandom);
            s = v.base + AW'(k);
            push_beat(s, cfg_data);
            cyc();
            pop_check("beat");
        end
        // Offer one more word while in DONE; it must not be taken.
        cfg_valid = 1'b1;
        cfg_data  = WW'($urandom);
        check_ctl("done", 1'b0, 1'b1, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        check_ctl("idle", 1'b0, 1'b0, 1'b0);
        check_array("load_array");
    endtask

    initial begin
        int pat[6];
        int cnt;

        vecs[0] = '{3'd2, 4'd1, 1, 24'hFAC688};
        vecs[1] = '{3'd6, 4'd4, 4, 24'h123456};
        vecs[2] = '{3'd4, 4'd0, 0, 24'h000000};
        vecs[3] = '{3'd3, 4'd9, 8, 24'hABCDEF};
        vecs[4] = '{3'd0, 4'd8, 8, 24'h5A5A5A};
        pat = '{1, 0, 0, 1, 0, 1};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            start     = 1'($urandom);
            abort     = 1'($urandom);
            cfg_valid = 1'($urandom);
            base_slot = AW'($urandom);
            n_slots   = (AW+1)'($urandom);
            cfg_data  = WW'($urandom);
            cyc();
        end
        exp_arr = '0;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_array("reset_array");
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        check_ctl("post_reset", 1'b0, 1'b0, 1'b0);

        // Single slot: known field layout of 0xFAC688 is 0..7 by field index
        run_load(vecs[0]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2; j++)
                check($sformatf("single_field_r%0d_o%0d", i, j), 64'(sel_arr[i][j][2]), 64'(i*2+j));

        for (int t = 1; t < 5; t++) run_load(vecs[t]);

        // Backpressure: n=3 with gaps in cfg_valid
        base_slot = 3'd5; n_slots = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cnt = 0;
        for (int p = 0; p < 6; p++) begin
            check("bp_ready", 64'(cfg_ready), 64'd1);
            cfg_valid = pat[p][0];
            cfg_data  = WW'($urandom);
            if (pat[p] == 1) push_beat(3'd5 + AW'(cnt), cfg_data);
            cyc();
            if (pat[p] == 1) begin
                pop_check("bp_beat");
                cnt++;
            end
            check("bp_done", 64'(done), (p == 5) ? 64'd1 : 64'd0);
            check_array("bp_array");
        end
        cfg_valid = 1'b0;
        cyc();
        check_ctl("bp_idle", 1'b0, 1'b0, 1'b0);

        // Abort on beat 3, with an ignored start pulse before it
        base_slot = 3'd0; n_slots = 4'd4; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = WW'($urandom);
            push_beat(AW'(k), cfg_data);
            cyc();
            pop_check("ab_beat");
        end
        cfg_valid = 1'b0;
        base_slot = 3'd5; n_slots = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        check_ctl("ign_start", 1'b1, 1'b1, 1'b0);
        cfg_valid = 1'b1; abort = 1'b1; cfg_data = WW'($urandom);
        cyc();
        cfg_valid = 1'b0; abort = 1'b0;
        check_ctl("abort", 1'b0, 1'b0, 1'b0);
        check_array("abort_array");
        cyc();
        check_ctl("no_queue", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a load
        base_slot = 3'd4; n_slots = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = WW'($urandom);
        push_beat(3'd4, cfg_data);
        cyc();
        pop_check("mid_beat");
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        exp_arr = '0;
        check_ctl("mid_reset", 1'b0, 1'b0, 1'b0);
        check_array("mid_reset_array");
        run_load('{3'd7, 4'd2, 2, 24'h0F0F0F});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
